bcd_mul_seq: RTL and testbench

//  Sequential BCD multiplier: an unsigned DIGITS-digit BCD operand times one BCD digit.

---
 rtl/bcd_mul_pkg.sv | 22 ++
 rtl/bcd_digit_mul.sv | 22 ++
 rtl/bcd_mul_seq.sv | 143 ++++++++++++++
 tb/tb_bcd_mul_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_mul_pkg.sv
// Shared types and constants for the sequential BCD digit multiplier.
// Optional feature macro: BCD_MUL_EARLY_EXIT_EN (used by bcd_mul_seq).
package bcd_mul_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned BCD_MAX   = 9;
  localparam int unsigned BCD_RADIX = 10;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when the 4-bit code is a legal decimal digit.
  function automatic logic is_bcd(input bcd_digit_t digit);
    return digit <= DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_mul.sv
// Combinational single-digit BCD multiplier: x*y as two BCD digits {hi_c, lo_c}.
module bcd_digit_mul
  import bcd_mul_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  output logic [DIGIT_W-1:0] hi_c,
  output logic [DIGIT_W-1:0] lo_c
);

  localparam int unsigned PROD_W = 2 * DIGIT_W;

  logic [PROD_W-1:0] prod;

  // Binary product (max 81 for legal digits) split into tens and units.
  always_comb begin
    prod = PROD_W'(x) * PROD_W'(y);
    hi_c = DIGIT_W'(prod / PROD_W'(BCD_RADIX));
    lo_c = DIGIT_W'(prod % PROD_W'(BCD_RADIX));
  end

endmodule

// File: rtl/bcd_mul_seq.sv
// Sequential BCD multiplier: DIGITS-digit BCD operand times one BCD digit,
// one digit per clock, least significant digit first.
// Optional feature macro: BCD_MUL_EARLY_EXIT_EN -- finish as soon as the
// remaining multiplicand digits and the carry are all zero.
module bcd_mul_seq
  import bcd_mul_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DIGIT_W*DIGITS-1:0]     a,
  input  logic [DIGIT_W-1:0]            b,
  output logic                          busy,
  output logic                          done,
  output logic [DIGIT_W*(DIGITS+1)-1:0] p,
  output logic                          err
);

  localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned P_DIGITS = DIGITS + 1;
  localparam int unsigned SUM_W    = DIGIT_W + 1;

  state_t                           state;
  logic [DIGITS-1:0][DIGIT_W-1:0]   a_q;
  logic [DIGIT_W-1:0]               b_q;
  logic [DIGIT_W-1:0]               carry;
  logic [IDX_W-1:0]                 idx;
  logic [P_DIGITS-1:0][DIGIT_W-1:0] p_q;

  logic [DIGITS-1:0][DIGIT_W-1:0]   a_in;
  logic                             operands_ok;
  logic [DIGIT_W-1:0]               a_dig;
  logic [DIGIT_W-1:0]               hi;
  logic [DIGIT_W-1:0]               lo;
  logic [SUM_W-1:0]                 sum;
  logic [DIGIT_W-1:0]               dig;
  logic [DIGIT_W-1:0]               carry_nxt;
  logic                             last;
  logic                             finish;

  assign a_in  = a;
  assign a_dig = a_q[idx];
  assign last  = (idx == IDX_W'(DIGITS - 1));
  assign p     = p_q;

  // Every operand digit must be a legal decimal digit.
  always_comb begin
    operands_ok = is_bcd(b);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!is_bcd(a_in[i])) operands_ok = 1'b0;
    end
  end

  bcd_digit_mul u_digit_mul (
    .x    (a_dig),
    .y    (b_q),
    .hi_c (hi),
    .lo_c (lo)
  );

  // Add incoming carry to the low product digit and decimal-adjust.
  always_comb begin
    sum = SUM_W'(lo) + SUM_W'(carry);
    if (sum > SUM_W'(BCD_MAX)) begin
      dig       = DIGIT_W'(sum - SUM_W'(BCD_RADIX));
      carry_nxt = hi + DIGIT_W'(1);
    end else begin
      dig       = DIGIT_W'(sum);
      carry_nxt = hi;
    end
  end

`ifdef BCD_MUL_EARLY_EXIT_EN
  logic upper_zero;

  // Nothing left to contribute once all higher multiplicand digits are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (i > int'(idx) && a_q[i] != '0) upper_zero = 1'b0;
    end
  end

  // Higher product digits already hold their cleared zero, so stopping is exact.
  assign finish = last || ((upper_zero || b_q == '0) && carry_nxt == '0);
`else
  assign finish = last;
`endif

  // Control FSM with operand latch, digit index, carry chain and product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= '0;
      idx   <= '0;
      p_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a_in;
            b_q   <= b;
            carry <= '0;
            idx   <= '0;
            p_q   <= '0;
            if (operands_ok) begin
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= ST_MUL;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          p_q[idx] <= dig;
          carry    <= carry_nxt;
          idx      <= idx + IDX_W'(1);
          if (last) p_q[P_DIGITS-1] <= carry_nxt;
          if (finish) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_mul_seq.sv
// Self-checking bench for bcd_mul_seq (DIGITS=4). Honours BCD_MUL_EARLY_EXIT_EN.
module tb_bcd_mul_seq;

  localparam int DIGITS = 4;

`ifdef BCD_MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [3:0]  b;
  logic        busy;
  logic        done;
  logic [19:0] p;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (edge counts since reset release).
  int          edge_no;
  int          acc_edge;
  int          done_edge;
  int          free_at;
  logic [19:0] exp_p;
  logic        exp_err;

  always #5 clk = ~clk;

  bcd_mul_seq #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .err   (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit bcd_ok(input logic [15:0] av, input logic [3:0] bv);
    bit ok;
    logic [3:0] d;
    ok = (bv <= 4'd9);
    for (int i = 0; i < DIGITS; i++) begin
      d = av[4*i +: 4];
      if (d > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic int bcd2int(input logic [15:0] av);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(av[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [19:0] int2bcd(input int v);
    logic [19:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i <= DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Number of multiply cycles: all digits, or only as many as the product needs.
  function automatic int nmul(input int av, input int bv);
    int prod;
    int nd;
    int lim;
    prod = av * bv;
    nd   = 1;
    lim  = 10;
    if (!EARLY) return DIGITS;
    if (bv == 0) return 1;
    while (prod >= lim && nd < DIGITS) begin
      nd++;
      lim = lim * 10;
    end
    return nd;
  endfunction

  // Decimal reference: when each request is accepted and what it must yield.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_no   <= 0;
      acc_edge  <= -10;
      done_edge <= -10;
      free_at   <= 0;
      exp_p     <= '0;
      exp_err   <= 1'b0;
    end else begin
      edge_no <= edge_no + 1;
      if (start && (edge_no + 1) >= free_at) begin
        acc_edge <= edge_no + 1;
        if (bcd_ok(a, b)) begin
          exp_p     <= int2bcd(bcd2int(a) * int'(b));
          exp_err   <= 1'b0;
          done_edge <= edge_no + 1 + nmul(bcd2int(a), int'(b));
          free_at   <= edge_no + 3 + nmul(bcd2int(a), int'(b));
        end else begin
          exp_p     <= '0;
          exp_err   <= 1'b1;
          done_edge <= edge_no + 1;
          free_at   <= edge_no + 3;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_p",    32'(p),    32'(0));
      check("rst_err",  32'(err),  32'(0));
    end else begin
      check("busy", 32'(busy), 32'(edge_no >= acc_edge && edge_no < done_edge));
      check("done", 32'(done), 32'(edge_no == done_edge));
      if (edge_no >= done_edge) begin
        check("p",   32'(p),   32'(exp_p));
        check("err", 32'(err), 32'(exp_err));
      end
    end
  end

  // One request; waits (bounded) for done, then pins latency and results.
  task automatic run_op(input logic [15:0] av, input logic [3:0] bv, input logic [19:0] req_p,
                        input logic req_err, input int req_n, input int poke, input string name);
    int n;
    bit seen;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        start = (n == poke);
        if (n == poke) begin
          a = 16'h9999;
          b = 4'h9;
        end
      end
    end
    start = 1'b0;
    check({name, "_lat"}, 32'(n), 32'(req_n));
    check({name, "_p"},   32'(p), 32'(req_p));
    check({name, "_err"}, 32'(err), 32'(req_err));
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input int av, input int bv);
    return nmul(av, bv) + 1;
  endfunction

  initial begin
    int pulses;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #2;
    check("init_busy", 32'(busy), 32'(0));
    check("init_p",    32'(p),    32'(0));
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(16'h1234, 4'd5, 20'h06170, 1'b0, lat(1234, 5), -1, "t1");
    run_op(16'h9999, 4'd9, 20'h89991, 1'b0, lat(9999, 9), -1, "t2");
    run_op(16'h12A4, 4'd3, 20'h00000, 1'b1, 1, -1, "t3_bad_a");
    run_op(16'h0002, 4'd7, 20'h00014, 1'b0, lat(2, 7), 2, "t4");
    run_op(16'h1234, 4'hB, 20'h00000, 1'b1, 1, -1, "t3_bad_b");

    // Reset in the middle of an operation must clear outputs without a clock edge.
    a     = 16'h4321;
    b     = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t5_partial", 32'(p[7:0]), 32'h42);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_done", 32'(done), 32'(0));
    check("t5_p",    32'(p),    32'(0));
    check("t5_err",  32'(err),  32'(0));
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(16'h4321, 4'd2, 20'h08642, 1'b0, lat(4321, 2), -1, "t5");

    run_op(16'h0003, 4'd3, 20'h00009, 1'b0, lat(3, 3), -1, "t6a");
    run_op(16'h0005, 4'd4, 20'h00020, 1'b0, lat(5, 4), -1, "t6b");
    run_op(16'h0987, 4'd0, 20'h00000, 1'b0, lat(987, 0), -1, "t6c");
    run_op(16'h1000, 4'd1, 20'h01000, 1'b0, lat(1000, 1), -1, "edge_hi");

    // Start held high: ignored in DONE, re-accepted once idle.
    a      = 16'h0011;
    b      = 4'd3;
    start  = 1'b1;
    pulses = 0;
    @(posedge clk);
    for (int k = 0; k < 2 * lat(11, 3) + 1; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    @(posedge clk);
    #1 start = 1'b0;
    check("held_pulses", 32'(pulses), 32'(2));
    check("held_p", 32'(p), 32'h00033);
    @(posedge clk);
    #1;

    // Exhaustive single-digit sweep against decimal arithmetic.
    for (int x = 0; x < 10; x++) begin
      for (int y = 0; y < 10; y++) begin
        run_op(16'(x), 4'(y), int2bcd(x * y), 1'b0, lat(x, y), -1, "exh");
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
